// File: rtl/batcharger_adcseq.sv
// batcharger_adcseq: shares the charger's single 8-bit ADC between the
// battery voltage, current and temperature channels, round-robin.
//
// Ports:
//   clk, rstz        clock (rising edge), async active-low reset
//   en               block enable; low returns to IDLE, clears valids/error
//   vmonen/imonen/tmonen  channel requests from the charger controller
//   adc_sel          mux select (00=V, 01=I, 10=T), stable in SETTLE/CONV
//   adc_start        one-cycle conversion start pulse
//   adc_done/adc_data conversion complete strobe and result
//   vbat/ibat/tbat   latest result per channel
//   vtok             every enabled channel has a fresh sample, no error
//   adc_err          sticky conversion-timeout flag

module batcharger_adcseq #(
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       en,
    input  logic       vmonen,
    input  logic       imonen,
    input  logic       tmonen,
    output logic [1:0] adc_sel,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic [7:0] vbat,
    output logic [7:0] ibat,
    output logic [7:0] tbat,
    output logic       vtok,
    output logic       adc_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CONV   = 2'd2
    } state_t;

    localparam logic [1:0] CH_V = 2'd0;
    localparam logic [1:0] CH_I = 2'd1;
    localparam logic [1:0] CH_T = 2'd2;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    // The timeout fires in the TIMEOUT-th CONV cycle, i.e. when the
    // count of cycles already spent equals TIMEOUT-1.
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t     state;
    logic [1:0] last;
    logic       vv;
    logic       iv;
    logic       tv;
    logic [3:0] settle_cnt;
    logic [7:0] tmo_cnt;

    logic [3:0] mon;
    logic       any_mon;
    logic       sel_on;
    logic [1:0] pick;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;

    // Channel 3 is never selected; its request bit is tied low.
    assign mon     = {1'b0, tmonen, imonen, vmonen};
    assign any_mon = vmonen | imonen | tmonen;
    assign sel_on  = mon[adc_sel];

    function automatic logic [1:0] succ(input logic [1:0] ch);
        return (ch >= CH_T) ? CH_V : ch + 2'd1;
    endfunction

    // First enabled channel after last in V->I->T->V order.
    always_comb begin
        c1   = succ(last);
        c2   = succ(c1);
        c3   = succ(c2);
        pick = c3;
        if (mon[c1]) begin
            pick = c1;
        end else if (mon[c2]) begin
            pick = c2;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state      <= IDLE;
            last       <= CH_T;
            vv         <= 1'b0;
            iv         <= 1'b0;
            tv         <= 1'b0;
            settle_cnt <= 4'd0;
            tmo_cnt    <= 8'd0;
            adc_sel    <= CH_V;
            adc_start  <= 1'b0;
            vbat       <= 8'd0;
            ibat       <= 8'd0;
            tbat       <= 8'd0;
            vtok       <= 1'b0;
            adc_err    <= 1'b0;
        end else if (!en) begin
            state     <= IDLE;
            vv        <= 1'b0;
            iv        <= 1'b0;
            tv        <= 1'b0;
            adc_start <= 1'b0;
            vtok      <= 1'b0;
            adc_err   <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            if (!vmonen) vv <= 1'b0;
            if (!imonen) iv <= 1'b0;
            if (!tmonen) tv <= 1'b0;
            // Built from the registered valid bits, so one cycle behind.
            vtok <= any_mon & (!vmonen | vv) & (!imonen | iv)
                  & (!tmonen | tv) & !adc_err;

            case (state)
                IDLE: begin
                    if (any_mon) begin
                        adc_sel    <= pick;
                        settle_cnt <= SETTLE_LD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!sel_on) begin
                        state <= IDLE;
                    end else if (settle_cnt == 4'd0) begin
                        tmo_cnt   <= 8'd0;
                        adc_start <= 1'b1;
                        state     <= CONV;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CONV: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (!sel_on) begin
                        // Request withdrawn: drop the conversion, keep last.
                        state <= IDLE;
                    end else if (adc_done) begin
                        case (adc_sel)
                            CH_V: begin
                                vbat <= adc_data;
                                vv   <= 1'b1;
                            end
                            CH_I: begin
                                ibat <= adc_data;
                                iv   <= 1'b1;
                            end
                            CH_T: begin
                                tbat <= adc_data;
                                tv   <= 1'b1;
                            end
                            default: ;
                        endcase
                        last  <= adc_sel;
                        state <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Advance last so a dead channel cannot starve others.
                        adc_err <= 1'b1;
                        last    <= adc_sel;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_batcharger_adcseq.sv
// tb_batcharger_adcseq: self-checking bench for batcharger_adcseq with an
// ADC responder model and a slot-level reference model of the scheduler.

module tb_batcharger_adcseq;

    localparam int SETTLE = 4;
    localparam int TMO    = 63;

    logic       clk = 1'b0;
    logic       rstz;
    logic       en;
    logic       vmonen;
    logic       imonen;
    logic       tmonen;
    logic [1:0] adc_sel;
    logic       adc_start;
    logic       adc_done;
    logic [7:0] adc_data;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic       vtok;
    logic       adc_err;

    int npass  = 0;
    int ntotal = 0;
    int cyc    = 0;

    int         adc_lat = 0;
    int         pend    = 0;
    logic [7:0] cur_data;
    logic [7:0] resp_data [3];

    always #5 clk = ~clk;

    batcharger_adcseq #(
        .SETTLE_CYC(SETTLE),
        .TIMEOUT   (TMO)
    ) dut (
        .clk      (clk),
        .rstz     (rstz),
        .en       (en),
        .vmonen   (vmonen),
        .imonen   (imonen),
        .tmonen   (tmonen),
        .adc_sel  (adc_sel),
        .adc_start(adc_start),
        .adc_done (adc_done),
        .adc_data (adc_data),
        .vbat     (vbat),
        .ibat     (ibat),
        .tbat     (tbat),
        .vtok     (vtok),
        .adc_err  (adc_err)
    );

    // One clock; also steps the ADC model: adc_done comes adc_lat cycles
    // after a sampled adc_start (adc_lat = 0 means the ADC never answers).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        adc_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                adc_done = 1'b1;
                adc_data = cur_data;
            end
        end
        if (adc_start === 1'b1 && adc_lat > 0) begin
            pend     = adc_lat;
            cur_data = resp_data[int'(adc_sel) % 3];
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (adc_start !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (adc_start !== 1'b1) n = -1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (adc_done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (adc_done !== 1'b1) n = -1;
    endtask

    function automatic logic [7:0] reg_of(input int ch);
        return (ch == 0) ? vbat : (ch == 1) ? ibat : tbat;
    endfunction

    task automatic do_reset();
        rstz    = 1'b0;
        en      = 1'b0;
        vmonen  = 1'b0;
        imonen  = 1'b0;
        tmonen  = 1'b0;
        adc_lat = 0;
        pend    = 0;
        tick();
        tick();
        rstz = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        ntotal++; if (adc_sel !== 2'b00) $display("FAIL rst_sel got=%0h exp=0", adc_sel); else npass++;
        ntotal++; if (adc_start !== 1'b0) $display("FAIL rst_start got=%0b exp=0", adc_start); else npass++;
        ntotal++; if ({vbat, ibat, tbat} !== 24'h0) $display("FAIL rst_results got=%0h exp=0", {vbat, ibat, tbat}); else npass++;
        ntotal++; if (vtok !== 1'b0) $display("FAIL rst_vtok got=%0b exp=0", vtok); else npass++;
        ntotal++; if (adc_err !== 1'b0) $display("FAIL rst_err got=%0b exp=0", adc_err); else npass++;
    endtask

    task automatic test_single_v();
        int n;
        do_reset();
        resp_data[0] = 8'hB0;
        adc_lat = 3;
        en      = 1'b1;
        vmonen  = 1'b1;
        wait_start(n);
        ntotal++; if (n != SETTLE + 1) $display("FAIL single_start_lat got=%0d exp=%0d", n, SETTLE + 1); else npass++;
        ntotal++; if (adc_sel !== 2'b00) $display("FAIL single_sel got=%0h exp=0", adc_sel); else npass++;
        wait_done(n);
        ntotal++; if (n != 3) $display("FAIL single_done got=%0d exp=3", n); else npass++;
        tick();
        ntotal++; if (vbat !== 8'hB0) $display("FAIL single_vbat got=%0h exp=b0", vbat); else npass++;
        ntotal++; if (vtok !== 1'b0) $display("FAIL single_vtok_early got=%0b exp=0", vtok); else npass++;
        tick();
        ntotal++; if (vtok !== 1'b1) $display("FAIL single_vtok got=%0b exp=1", vtok); else npass++;
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_sel [4];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        resp_data = '{8'h11, 8'h22, 8'h33};
        adc_lat = 2;
        en      = 1'b1;
        vmonen  = 1'b1;
        imonen  = 1'b1;
        tmonen  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start(n);
            ntotal++; if (n < 0 || adc_sel !== exp_sel[k]) $display("FAIL rr_sel%0d got=%0h exp=%0h", k, adc_sel, exp_sel[k]); else npass++;
            wait_done(n);
            tick();
            ntotal++; if (reg_of(int'(exp_sel[k])) !== resp_data[exp_sel[k]]) $display("FAIL rr_result%0d got=%0h exp=%0h", k, reg_of(int'(exp_sel[k])), resp_data[exp_sel[k]]); else npass++;
            tick();
            ntotal++; if (vtok !== (k >= 2)) $display("FAIL rr_vtok%0d got=%0b exp=%0b", k, vtok, k >= 2); else npass++;
        end
    endtask

    task automatic test_timeout();
        int n;
        int k;
        do_reset();
        adc_lat = 0;
        en      = 1'b1;
        vmonen  = 1'b1;
        imonen  = 1'b1;
        wait_start(n);
        k = 0;
        while (adc_err !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        ntotal++; if (k != TMO) $display("FAIL tmo_cycles got=%0d exp=%0d", k, TMO); else npass++;
        ntotal++; if (vtok !== 1'b0) $display("FAIL tmo_vtok got=%0b exp=0", vtok); else npass++;
        wait_start(n);
        ntotal++; if (n < 0 || adc_sel !== 2'b01) $display("FAIL tmo_next_sel got=%0h exp=1", adc_sel); else npass++;
        ntotal++; if (adc_err !== 1'b1) $display("FAIL tmo_sticky got=%0b exp=1", adc_err); else npass++;
        en = 1'b0;
        tick();
        en = 1'b1;
        ntotal++; if (adc_err !== 1'b0) $display("FAIL tmo_en_clear got=%0b exp=0", adc_err); else npass++;
    endtask

    task automatic test_timeout_edge();
        int n;
        do_reset();
        resp_data[0] = 8'h5A;
        adc_lat = TMO - 1;
        en      = 1'b1;
        vmonen  = 1'b1;
        wait_start(n);
        wait_done(n);
        ntotal++; if (n != TMO - 1) $display("FAIL edge_done got=%0d exp=%0d", n, TMO - 1); else npass++;
        tick();
        ntotal++; if (vbat !== 8'h5A) $display("FAIL edge_vbat got=%0h exp=5a", vbat); else npass++;
        ntotal++; if (adc_err !== 1'b0) $display("FAIL edge_err got=%0b exp=0", adc_err); else npass++;
        do_reset();
        resp_data[0] = 8'hA5;
        adc_lat = TMO;
        en      = 1'b1;
        vmonen  = 1'b1;
        wait_start(n);
        wait_done(n);
        tick();
        ntotal++; if (vbat !== 8'h00) $display("FAIL late_vbat got=%0h exp=0", vbat); else npass++;
        ntotal++; if (adc_err !== 1'b1) $display("FAIL late_err got=%0b exp=1", adc_err); else npass++;
    endtask

    task automatic test_drop_t();
        int n;
        bit ok;
        do_reset();
        resp_data = '{8'h11, 8'h22, 8'h33};
        adc_lat = 2;
        en      = 1'b1;
        vmonen  = 1'b1;
        imonen  = 1'b1;
        tmonen  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_start(n);
            wait_done(n);
            tick();
            tick();
        end
        resp_data[2] = 8'h77;
        wait_start(n);
        ntotal++; if (n < 0 || adc_sel !== 2'b10) $display("FAIL drop_sel got=%0h exp=2", adc_sel); else npass++;
        tmonen = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (vtok !== 1'b1) ok = 1'b0;
        end
        ntotal++; if (!ok) $display("FAIL drop_vtok_held got=0 exp=1"); else npass++;
        ntotal++; if (tbat !== 8'h33) $display("FAIL drop_tbat got=%0h exp=33", tbat); else npass++;
        tmonen = 1'b1;
        tick();
        ntotal++; if (vtok !== 1'b0) $display("FAIL drop_tv_clear got=%0b exp=0", vtok); else npass++;
    endtask

    task automatic test_mid_reset();
        int n;
        do_reset();
        resp_data[1] = 8'hC3;
        adc_lat = 3;
        en      = 1'b1;
        imonen  = 1'b1;
        wait_start(n);
        wait_done(n);
        tick();
        tick();
        ntotal++; if (ibat !== 8'hC3 || vtok !== 1'b1) $display("FAIL mid_pre got=%0h/%0b exp=c3/1", ibat, vtok); else npass++;
        wait_start(n);
        tick();
        rstz   = 1'b0;
        imonen = 1'b0;
        #1;
        ntotal++; if (adc_sel !== 2'b00) $display("FAIL mid_sel got=%0h exp=0", adc_sel); else npass++;
        ntotal++; if (ibat !== 8'h00) $display("FAIL mid_ibat got=%0h exp=0", ibat); else npass++;
        ntotal++; if (vtok !== 1'b0 || adc_start !== 1'b0 || adc_err !== 1'b0) $display("FAIL mid_flags got=%0b%0b%0b exp=000", vtok, adc_start, adc_err); else npass++;
        rstz = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        ntotal++; if (ibat !== 8'h00 || adc_err !== 1'b0) $display("FAIL mid_late_done got=%0h/%0b exp=0/0", ibat, adc_err); else npass++;
        ntotal++; if (adc_sel !== 2'b00 || vtok !== 1'b0) $display("FAIL mid_hold got=%0h/%0b exp=0/0", adc_sel, vtok); else npass++;
    endtask

    // Reference: cyclic pick after the last serviced channel, slot length
    // 1 + SETTLE + L + 1, per-channel latest value and valid flags.
    task automatic test_random();
        int n;
        int ch;
        int mlast;
        int nslot;
        int prev_start;
        int prev_lat;
        logic [2:0] mask;
        logic [7:0] mreg [3];
        bit mvalid [3];
        bit vt;
        do_reset();
        mlast = 2;
        prev_start = 0;
        prev_lat = 0;
        for (int ep = 0; ep < 6; ep++) begin
            mask   = 3'($urandom_range(1, 7));
            vmonen = mask[0];
            imonen = mask[1];
            tmonen = mask[2];
            mvalid = '{0, 0, 0};
            en     = 1'b1;
            nslot  = $urandom_range(3, 6);
            for (int s = 0; s < nslot; s++) begin
                adc_lat = $urandom_range(1, 12);
                for (int c = 0; c < 3; c++) resp_data[c] = 8'($urandom);
                ch = -1;
                for (int k = 1; k <= 3; k++) begin
                    if (ch < 0 && mask[(mlast + k) % 3]) ch = (mlast + k) % 3;
                end
                wait_start(n);
                ntotal++; if (n < 0 || int'(adc_sel) != ch) $display("FAIL rnd_sel e%0d s%0d got=%0d exp=%0d", ep, s, adc_sel, ch); else npass++;
                if (s > 0) begin
                    ntotal++; if (cyc - prev_start != SETTLE + prev_lat + 2) $display("FAIL rnd_slot e%0d s%0d got=%0d exp=%0d", ep, s, cyc - prev_start, SETTLE + prev_lat + 2); else npass++;
                end
                prev_start = cyc;
                prev_lat   = adc_lat;
                wait_done(n);
                ntotal++; if (n != adc_lat) $display("FAIL rnd_lat e%0d s%0d got=%0d exp=%0d", ep, s, n, adc_lat); else npass++;
                mreg[ch]   = resp_data[ch];
                mvalid[ch] = 1'b1;
                mlast      = ch;
                tick();
                ntotal++; if (reg_of(ch) !== mreg[ch]) $display("FAIL rnd_result e%0d s%0d got=%0h exp=%0h", ep, s, reg_of(ch), mreg[ch]); else npass++;
                tick();
                vt = (!mask[0] || mvalid[0]) && (!mask[1] || mvalid[1]) && (!mask[2] || mvalid[2]);
                ntotal++; if (vtok !== vt) $display("FAIL rnd_vtok e%0d s%0d got=%0b exp=%0b", ep, s, vtok, vt); else npass++;
            end
            en = 1'b0;
            tick();
            ntotal++; if (vtok !== 1'b0) $display("FAIL rnd_en_off e%0d got=%0b exp=0", ep, vtok); else npass++;
        end
    endtask

    initial begin
        rstz      = 1'b0;
        en        = 1'b0;
        vmonen    = 1'b0;
        imonen    = 1'b0;
        tmonen    = 1'b0;
        adc_done  = 1'b0;
        adc_data  = 8'h00;
        cur_data  = 8'h00;
        resp_data = '{8'h00, 8'h00, 8'h00};
        test_reset();
        test_single_v();
        test_round_robin();
        test_timeout();
        test_timeout_edge();
        test_drop_t();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/batcharger_adcseq.md
# batcharger_adcseq

Scheduler that shares the charger's single 8-bit ADC between the battery voltage, current and temperature channels. It reads the monitor-enable outputs of the charger controller (`vmonen`, `imonen`, `tmonen`) and converts the enabled channels round-robin. It holds the latest `vbat`/`ibat`/`tbat` codes and asserts `vtok` once every enabled channel has a fresh sample. It sits between the ADC macro and the charger controller and drives the controller's ADC-side inputs.

## Interface
Parameters:
- `SETTLE_CYC`, default 4: cycles the mux select is held stable before a conversion starts; legal range 1–15.
- `TIMEOUT`, default 63: maximum CONV cycles to wait for `adc_done`; legal range 2–255.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rstz`  in  1  reset; asynchronous, active-low.
- `en`  in  1  block enable; low forces a synchronous return to IDLE and clears all valid bits.
- `vmonen`  in  1  voltage channel requested.
- `imonen`  in  1  current channel requested.
- `tmonen`  in  1  temperature channel requested.
- `adc_sel`  out  2  analog mux select: 00 = V, 01 = I, 10 = T; 11 is never driven.
- `adc_start`  out  1  one-cycle conversion-start pulse.
- `adc_done`  in  1  conversion complete; `adc_data` is valid in the same cycle.
- `adc_data`  in  8  conversion result.
- `vbat`  out  8  latest voltage code.
- `ibat`  out  8  latest current code.
- `tbat`  out  8  latest temperature code.
- `vtok`  out  1  every enabled channel holds a valid sample, and no error is pending.
- `adc_err`  out  1  sticky conversion-timeout flag.

## Operation
- States: IDLE, SETTLE, CONV.
- Registers: `last` (2 bits, last serviced channel), three valid bits `vv`/`iv`/`tv`, settle counter (4 bits), timeout counter (8 bits).

IDLE:
- Requires `en` = 1 and at least one monitor enable high.
- Picks the next enabled channel after `last` in cyclic order V→I→T→V. `last` resets to T, so the first pick is V.
- Registers the pick into `adc_sel`, loads the settle counter with `SETTLE_CYC-1`, and moves to SETTLE.
- If no channel is enabled, stays in IDLE and holds `adc_sel`.

SETTLE:
- Decrements the counter each cycle.
- When the counter reaches 0, moves to CONV and clears the timeout counter.

CONV:
- `adc_start` = 1 in the first CONV cycle only. The timeout counter increments every CONV cycle.
- On `adc_done` = 1:
  - The result register for the `adc_sel` channel loads `adc_data` on that edge.
  - That channel's valid bit sets and `last` updates to that channel.
  - The block returns to IDLE.
- If the counter equals `TIMEOUT` with no `adc_done`: `adc_err` sets, the result is discarded, and the block goes to IDLE with `last` still updated, so the next channel gets a turn. `adc_done` in the same cycle as the timeout wins and counts as a normal completion.
- `adc_done` outside CONV is ignored.

Valid bits:
- A valid bit clears on the cycle its monitor enable is low.
- If the selected channel's enable drops during SETTLE or CONV, the block aborts to IDLE with no store, and `last` is unchanged.

Error and ready flags:
- `vtok` = `en` & (`vmonen`|`imonen`|`tmonen`) & (!`vmonen`|`vv`) & (!`imonen`|`iv`) & (!`tmonen`|`tv`) & !`adc_err`. It is registered, so it is one cycle behind the valid bits.
- `adc_err` clears only on `rstz` or `en` = 0.

`en` = 0:
- Forces IDLE, clears the valid bits and `vtok`, and sets `adc_start` = 0.
- Result registers and `adc_sel` hold their values.

## Timing
- Reset values:
  - state IDLE, `last` = T, all counters 0.
  - `adc_sel` = 00, `adc_start` = 0.
  - `vbat` = `ibat` = `tbat` = 0.
  - `vv` = `iv` = `tv` = 0, `vtok` = 0, `adc_err` = 0.
- Slot latency, IDLE to IDLE, for ADC latency L (cycles from `adc_start` to `adc_done`, L ≥ 1): 1 (IDLE) + `SETTLE_CYC` + L + 1 cycles.
- `vtok` rises one cycle after the final required valid bit sets.
- Sample period per channel with N channels enabled: N × slot latency.
- `adc_start` never appears on two consecutive cycles.
- `adc_sel` changes only on the IDLE→SETTLE edge and is stable for the whole of SETTLE and CONV.
- `rstz` deasserted mid-conversion returns the block to the reset state. A late `adc_done` after that is ignored.

## Test plan
- Reset, then `en` = 1 with only `vmonen` = 1 and the ADC model at L = 3, returning 0xB0:
  - `adc_sel` = 00.
  - `adc_start` fires 5 cycles after IDLE exit (SETTLE = 4).
  - `vbat` = 0xB0.
  - `vtok` = 1 exactly 2 cycles after `adc_done`.
- All three enables high, ADC returns 0x11/0x22/0x33 by channel:
  - Select order is 00, 01, 10, 00…
  - Results land in `vbat`/`ibat`/`tbat` respectively.
  - `vtok` rises only after the first T sample.
- ADC never asserts `adc_done`:
  - `adc_err` = 1 after exactly 63 CONV cycles, and `vtok` = 0.
  - The next slot selects the following channel.
  - Toggling `en` low for 1 cycle clears `adc_err`.
- `adc_done` arrives on the timeout cycle itself:
  - Stored as a normal result, and `adc_err` stays 0.
- Drop `tmonen` during a T conversion:
  - The block aborts with `tbat` unchanged and `tv` = 0.
  - `vtok` stays high if V and I are valid and enabled.
- Assert `rstz` = 0 in mid-CONV:
  - All outputs return to their reset values immediately.
  - An `adc_done` pulse after release has no effect.
